// File: rtl/p1_anim_seq.sv
// Player-1 animation sequencer: action/frame FSM stepped on frame_tick, plus a
// 3-stage in-order sprite-row fetch pipeline (addr -> ROM -> mirror) with no backpressure.
module p1_anim_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        mv_fwd,
  input  logic        mv_back,
  input  logic        punch,
  input  logic        kick,
  input  logic        facing_left,
  input  logic        row_req,
  input  logic [3:0]  row_idx,
  input  logic [15:0] rom_bitmap,
  output logic [9:0]  rom_addr,
  output logic [2:0]  action,
  output logic [1:0]  frame,
  output logic        busy,
  output logic        attack_hit,
  output logic [15:0] row_data,
  output logic        row_valid
);

  typedef enum logic [2:0] {
    ST_STAY  = 3'd0,
    ST_FWD   = 3'd1,
    ST_BACK  = 3'd2,
    ST_PUNCH = 3'd3,
    ST_KICK  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt, w_decode;
  logic [1:0]  r_frame, w_frame_nxt;
  logic        r_busy, r_hit, w_hit_nxt, w_attack;

  logic [9:0]  r_rom_addr;
  logic        r_v0, r_f0, r_v1, r_f1;
  logic [15:0] r_row_data, w_rev;
  logic        r_row_valid;

  always_comb begin
    w_decode    = ST_STAY;
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_hit_nxt   = 1'b0;
    w_attack    = (r_state == ST_PUNCH) || (r_state == ST_KICK);

    if (kick)                    w_decode = ST_KICK;
    else if (punch)              w_decode = ST_PUNCH;
    else if (mv_fwd && !mv_back) w_decode = ST_FWD;
    else if (mv_back && !mv_fwd) w_decode = ST_BACK;

    if (frame_tick) begin
      // Attacks run to their last frame before any request is looked at.
      if (w_attack && (r_frame != 2'd3)) begin
        w_frame_nxt = r_frame + 2'd1;
        w_hit_nxt   = (r_frame == 2'd1);
      end else if (!w_attack && (w_decode == r_state)) begin
        w_frame_nxt = r_frame + 2'd1;
      end else begin
        w_state_nxt = w_decode;
        w_frame_nxt = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STAY;
      r_frame <= 2'd0;
      r_busy  <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_busy  <= (w_state_nxt == ST_PUNCH) || (w_state_nxt == ST_KICK);
      r_hit   <= w_hit_nxt;
    end
  end

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 16; i++) w_rev[i] = rom_bitmap[15-i];
  end

  // Address uses the pre-tick action/frame, so a row is never split across frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr  <= '0;
      r_v0        <= 1'b0;
      r_f0        <= 1'b0;
      r_v1        <= 1'b0;
      r_f1        <= 1'b0;
      r_row_data  <= '0;
      r_row_valid <= 1'b0;
    end else begin
      if (row_req) r_rom_addr <= {row_idx, r_state, 1'b0, r_frame};
      r_v0        <= row_req;
      r_f0        <= facing_left;
      r_v1        <= r_v0;
      r_f1        <= r_f0;
      r_row_valid <= r_v1;
      if (r_v1) r_row_data <= r_f1 ? w_rev : rom_bitmap;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign action     = r_state;
  assign frame      = r_frame;
  assign busy       = r_busy;
  assign attack_hit = r_hit;
  assign row_data   = r_row_data;
  assign row_valid  = r_row_valid;

endmodule
